// File: rtl/cbus_interconnect.sv
// Single-master common-bus interconnect: registered base/mask decode, one-hot slave
// select, error response for unmapped addresses and hung slaves, sticky error capture.
module cbus_interconnect #(
  parameter int                         NUM_SLAVES     = 6,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = {NUM_SLAVES{32'h0000_0000}},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK     = {NUM_SLAVES{32'hFF00_0000}},
  parameter int                         TIMEOUT_CYCLES = 256,
  parameter logic [31:0]                ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    m_valid,
  output logic                    m_ready,
  input  logic [31:0]             m_addr,
  input  logic [31:0]             m_wdata,
  input  logic [3:0]              m_wstrb,
  output logic [31:0]             m_rdata,
  output logic [NUM_SLAVES-1:0]   s_valid,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  output logic [3:0]              s_wstrb,
  input  logic [NUM_SLAVES-1:0]   s_ready,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  input  logic                    err_clear,
  output logic                    err_valid,
  output logic [1:0]              err_cause,
  output logic [31:0]             err_addr,
  output logic [7:0]              err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_ERROR  = 2'b10
  } state_t;

  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);
  localparam logic [1:0]  CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0]  CAUSE_TIMEOUT  = 2'b10;

  state_t                r_state;
  logic [NUM_SLAVES-1:0] r_sel;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [15:0]           r_cnt;
  logic                  r_err_valid;
  logic [1:0]            r_err_cause;
  logic [31:0]           r_err_addr;
  logic [7:0]            r_err_count;

  logic [NUM_SLAVES-1:0] w_hit;
  logic [NUM_SLAVES-1:0] w_hit_sel;
  logic                  w_sel_ready;
  logic [31:0]           w_sel_rdata;
  logic                  w_timeout;
  logic                  w_err_event;
  logic [1:0]            w_err_cause;
  logic [31:0]           w_err_addr;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_hit
    assign w_hit[g] = ((m_addr & SLAVE_MASK[32*g +: 32]) ==
                       (SLAVE_BASE[32*g +: 32] & SLAVE_MASK[32*g +: 32]));
  end

  // Overlapping windows resolve to the lowest slave index.
  always_comb begin
    logic found;
    found     = 1'b0;
    w_hit_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_hit[i] && !found) begin
        w_hit_sel[i] = 1'b1;
        found        = 1'b1;
      end else begin
        w_hit_sel[i] = 1'b0;
      end
    end
  end

  // Response mux from the registered one-hot select.
  always_comb begin
    w_sel_ready = |(s_ready & r_sel);
    w_sel_rdata = 32'h0000_0000;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_sel_rdata = w_sel_rdata | (s_rdata[32*i +: 32] & {32{r_sel[i]}});
    end
  end

  assign w_timeout = (TIMEOUT_LIMIT != 17'd0) && (({1'b0, r_cnt} + 17'd1) == TIMEOUT_LIMIT);

  // Flags the cycle whose clock edge enters ERROR, with the cause and address to log.
  always_comb begin
    w_err_event = 1'b0;
    w_err_cause = 2'b00;
    w_err_addr  = r_addr;
    case (r_state)
      ST_IDLE: begin
        if (m_valid && (w_hit_sel == '0)) begin
          w_err_event = 1'b1;
          w_err_cause = CAUSE_UNMAPPED;
          w_err_addr  = m_addr;
        end else begin
          w_err_event = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (m_valid && !w_sel_ready && w_timeout) begin
          w_err_event = 1'b1;
          w_err_cause = CAUSE_TIMEOUT;
        end else begin
          w_err_event = 1'b0;
        end
      end
      default: w_err_event = 1'b0;
    endcase
  end

  // Main FSM: decode in IDLE, wait for the selected slave, one-cycle error reply.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_wstrb <= 4'h0;
      r_cnt   <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= 16'h0000;
          if (m_valid) begin
            r_addr  <= m_addr;
            r_wdata <= m_wdata;
            r_wstrb <= m_wstrb;
            r_sel   <= w_hit_sel;
            r_state <= (w_hit_sel != '0) ? ST_ACCESS : ST_ERROR;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (w_sel_ready || !m_valid) begin
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_state <= ST_ERROR;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_ERROR: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky capture of the first error; count keeps running and saturates.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_valid <= 1'b0;
      r_err_cause <= 2'b00;
      r_err_addr  <= 32'h0000_0000;
      r_err_count <= 8'h00;
    end else if (err_clear && w_err_event) begin
      r_err_valid <= 1'b1;
      r_err_cause <= w_err_cause;
      r_err_addr  <= w_err_addr;
      r_err_count <= 8'h01;
    end else if (err_clear) begin
      r_err_valid <= 1'b0;
      r_err_cause <= 2'b00;
      r_err_addr  <= 32'h0000_0000;
      r_err_count <= 8'h00;
    end else if (w_err_event) begin
      if (r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'h01;
      end
      if (!r_err_valid) begin
        r_err_valid <= 1'b1;
        r_err_cause <= w_err_cause;
        r_err_addr  <= w_err_addr;
      end
    end
  end

  // Master-side response is combinational on the selected slave's ready.
  always_comb begin
    m_ready = 1'b0;
    m_rdata = 32'h0000_0000;
    case (r_state)
      ST_ACCESS: begin
        m_ready = w_sel_ready;
        m_rdata = w_sel_ready ? w_sel_rdata : 32'h0000_0000;
      end
      ST_ERROR: begin
        m_ready = 1'b1;
        m_rdata = ERR_RDATA;
      end
      default: begin
        m_ready = 1'b0;
        m_rdata = 32'h0000_0000;
      end
    endcase
  end

  assign s_valid   = (r_state == ST_ACCESS) ? r_sel : '0;
  assign s_wstrb   = (r_state == ST_ACCESS) ? r_wstrb : 4'h0;
  assign s_addr    = r_addr;
  assign s_wdata   = r_wdata;
  assign err_valid = r_err_valid;
  assign err_cause = r_err_cause;
  assign err_addr  = r_err_addr;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_cbus_interconnect.sv
// Scenario bench for cbus_interconnect: wait-state slave models, a request scoreboard
// and per-feature tasks checking latency, routing, error replies and error capture.
module tb_cbus_interconnect;

  localparam int NS = 6;

  logic           clk;
  logic           resetn;
  logic           m_valid;
  logic           m_ready;
  logic [31:0]    m_addr;
  logic [31:0]    m_wdata;
  logic [3:0]     m_wstrb;
  logic [31:0]    m_rdata;
  logic [NS-1:0]  s_valid;
  logic [31:0]    s_addr;
  logic [31:0]    s_wdata;
  logic [3:0]     s_wstrb;
  logic [NS-1:0]  s_ready;
  logic [NS*32-1:0] s_rdata;
  logic           err_clear;
  logic           err_valid;
  logic [1:0]     err_cause;
  logic [31:0]    err_addr;
  logic [7:0]     err_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]    cfg_wait [NS];
  logic [NS-1:0] cfg_hang;
  logic [NS-1:0] extra_ready;
  logic [NS-1:0] model_ready;
  logic [7:0]    wcnt [NS];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [5:0]  sel;
    logic        err;
    int          lat;
    logic [31:0] rdata;
    int          svc;
  } exp_t;
  exp_t sb[$];

  cbus_interconnect #(
    .NUM_SLAVES    (NS),
    .SLAVE_BASE    ({32'h4000_0000, 32'h3000_0000, 32'h3000_0000,
                     32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLAVE_MASK    ({32'hFF00_0000, 32'hF000_0000, 32'hFF00_0000,
                     32'hFF00_0000, 32'hFFFF_0000, 32'hFF00_0000}),
    .TIMEOUT_CYCLES(8),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .err_clear(err_clear), .err_valid(err_valid), .err_cause(err_cause),
    .err_addr(err_addr), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave i returns 0xC0DE0000 + i*0x101 on its read-data slice.
  for (genvar g = 0; g < NS; g++) begin : g_rdata
    assign s_rdata[32*g +: 32] = 32'hC0DE_0000 + 32'(g) * 32'h0000_0101;
  end

  always_comb begin
    model_ready = '0;
    for (int i = 0; i < NS; i++) begin
      model_ready[i] = s_valid[i] && !cfg_hang[i] && (wcnt[i] >= cfg_wait[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (s_valid[i] && !model_ready[i]) wcnt[i] <= wcnt[i] + 8'd1;
      else                               wcnt[i] <= 8'd0;
    end
  end

  assign s_ready = model_ready | extra_ready;

  task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [5:0] sel, input logic err,
                         input int lat, input logic [31:0] rdata, input int svc,
                         input logic keep);
    exp_t e;
    int n;
    int svc_obs;
    logic got;
    logic bad;
    logic [31:0] rd, sa, sw;
    logic [5:0] sv;
    logic [3:0] ss;
    e.addr = addr; e.wdata = wdata; e.wstrb = wstrb; e.sel = sel;
    e.err = err; e.lat = lat; e.rdata = rdata; e.svc = svc;
    sb.push_back(e);
    @(posedge clk); #1;
    m_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
    n = 0; svc_obs = 0; got = 1'b0; bad = 1'b0;
    rd = 32'h0; sa = 32'h0; sw = 32'h0; sv = 6'h0; ss = 4'h0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (s_valid != 6'h00) svc_obs++;
      if (s_valid != 6'h00 && s_valid != e.sel) bad = 1'b1;
      if (m_ready) begin
        got = 1'b1; rd = m_rdata; sv = s_valid; sa = s_addr; sw = s_wdata; ss = s_wstrb;
      end
    end
    e = sb.pop_front();
    checks++;
    if (got !== 1'b1) begin
      errors++; $display("FAIL req_done addr=%h: no m_ready within %0d cycles", e.addr, n);
    end
    checks++;
    if (n !== e.lat) begin
      errors++; $display("FAIL latency addr=%h: got %0d expected %0d", e.addr, n, e.lat);
    end
    checks++;
    if (rd !== e.rdata) begin
      errors++; $display("FAIL m_rdata addr=%h: got %h expected %h", e.addr, rd, e.rdata);
    end
    checks++;
    if (sv !== (e.err ? 6'h00 : e.sel)) begin
      errors++; $display("FAIL s_valid_at_ready addr=%h: got %b expected %b", e.addr, sv,
                         e.err ? 6'h00 : e.sel);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL s_valid_stray addr=%h: got bits outside %b", e.addr, e.sel);
    end
    checks++;
    if (svc_obs !== e.svc) begin
      errors++; $display("FAIL s_valid_cycles addr=%h: got %0d expected %0d", e.addr, svc_obs, e.svc);
    end
    if (!e.err) begin
      checks++;
      if ({sa, sw, ss} !== {e.addr, e.wdata, e.wstrb}) begin
        errors++; $display("FAIL s_bus addr=%h: got %h/%h/%h expected %h/%h/%h", e.addr,
                           sa, sw, ss, e.addr, e.wdata, e.wstrb);
      end
    end
    if (!keep) begin
      @(posedge clk); #1;
      m_valid = 1'b0; m_wstrb = 4'h0;
    end
  endtask

  task automatic check_err(input string name, input logic v, input logic [1:0] c,
                           input logic [31:0] a, input logic [7:0] cnt);
    @(negedge clk);
    checks++;
    if ({err_valid, err_cause, err_addr, err_count} !== {v, c, a, cnt}) begin
      errors++;
      $display("FAIL %s: got valid=%b cause=%b addr=%h count=%0d expected valid=%b cause=%b addr=%h count=%0d",
               name, err_valid, err_cause, err_addr, err_count, v, c, a, cnt);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({s_valid, s_wstrb, s_addr, s_wdata, m_ready, m_rdata} !== '0) begin
      errors++; $display("FAIL reset_outputs: got s_valid=%b s_wstrb=%h s_addr=%h s_wdata=%h m_ready=%b m_rdata=%h expected all 0",
                         s_valid, s_wstrb, s_addr, s_wdata, m_ready, m_rdata);
    end
    check_err("reset_err", 1'b0, 2'b00, 32'h0, 8'd0);
  endtask

  task automatic test_sram_read;
    cfg_wait[1] = 8'd0;
    run_req(32'h1000_0004, 32'h0, 4'h0, 6'b000010, 1'b0, 2, 32'hC0DE_0101, 1, 1'b0);
  endtask

  task automatic test_slave5_write;
    cfg_wait[5] = 8'd3;
    run_req(32'h4000_0000, 32'h1234_5678, 4'hF, 6'b100000, 1'b0, 5, 32'hC0DE_0505, 4, 1'b0);
  endtask

  task automatic test_priority;
    cfg_wait[3] = 8'd0;
    cfg_wait[4] = 8'd1;
    run_req(32'h3010_0000, 32'h0, 4'h0, 6'b001000, 1'b0, 2, 32'hC0DE_0303, 1, 1'b0);
    run_req(32'h3100_0000, 32'hA5A5_0001, 4'h3, 6'b010000, 1'b0, 3, 32'hC0DE_0404, 2, 1'b0);
  endtask

  task automatic test_ignore_unselected;
    cfg_wait[2] = 8'd2;
    extra_ready = 6'b111011;
    run_req(32'h2000_0010, 32'h0, 4'h0, 6'b000100, 1'b0, 4, 32'hC0DE_0202, 3, 1'b0);
    extra_ready = 6'b000000;
  endtask

  task automatic test_back_to_back;
    cfg_wait[0] = 8'd0;
    run_req(32'h1000_0008, 32'h0, 4'h0, 6'b000010, 1'b0, 2, 32'hC0DE_0101, 1, 1'b1);
    run_req(32'h0000_0004, 32'h5555_AAAA, 4'h1, 6'b000001, 1'b0, 2, 32'hC0DE_0000, 1, 1'b0);
  endtask

  task automatic test_abort;
    logic saw_ready;
    cfg_hang[0] = 1'b1;
    saw_ready = 1'b0;
    @(posedge clk); #1;
    m_valid = 1'b1; m_addr = 32'h0000_0008; m_wstrb = 4'h0;
    repeat (3) begin
      @(negedge clk);
      if (m_ready) saw_ready = 1'b1;
    end
    @(posedge clk); #1;
    m_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (m_ready) saw_ready = 1'b1;
    end
    checks++;
    if ({saw_ready, s_valid} !== 7'b0) begin
      errors++; $display("FAIL abort: got m_ready_seen=%b s_valid=%b expected 0/000000", saw_ready, s_valid);
    end
    check_err("abort_err", 1'b0, 2'b00, 32'h0, 8'd0);
  endtask

  task automatic test_unmapped;
    run_req(32'h5000_0000, 32'h0, 4'h0, 6'b000000, 1'b1, 2, 32'hDEAD_BEEF, 0, 1'b0);
    check_err("unmapped_err", 1'b1, 2'b01, 32'h5000_0000, 8'd1);
  endtask

  task automatic test_timeout;
    @(posedge clk); #1; err_clear = 1'b1;
    @(posedge clk); #1; err_clear = 1'b0;
    check_err("clear_err", 1'b0, 2'b00, 32'h0, 8'd0);
    cfg_hang[0] = 1'b1;
    run_req(32'h0000_0040, 32'h0, 4'h0, 6'b000001, 1'b1, 10, 32'hDEAD_BEEF, 8, 1'b0);
    check_err("timeout_err", 1'b1, 2'b10, 32'h0000_0040, 8'd1);
    run_req(32'h5000_0010, 32'h0, 4'h0, 6'b000000, 1'b1, 2, 32'hDEAD_BEEF, 0, 1'b0);
    check_err("second_err_sticky", 1'b1, 2'b10, 32'h0000_0040, 8'd2);
  endtask

  task automatic test_clear_collision;
    fork
      run_req(32'h0000_0080, 32'h0, 4'h0, 6'b000001, 1'b1, 10, 32'hDEAD_BEEF, 8, 1'b0);
      begin
        repeat (9) @(posedge clk);
        #1 err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
      end
    join
    check_err("clear_collision", 1'b1, 2'b10, 32'h0000_0080, 8'd1);
  endtask

  task automatic test_saturate;
    @(posedge clk); #1;
    m_valid = 1'b1; m_addr = 32'h5000_0000; m_wstrb = 4'h0;
    repeat (600) @(posedge clk);
    #1 m_valid = 1'b0;
    repeat (3) @(posedge clk);
    check_err("count_saturate", 1'b1, 2'b10, 32'h0000_0080, 8'd255);
  endtask

  task automatic test_reset_mid_access;
    cfg_hang[0] = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b1; m_addr = 32'h0000_0100; m_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (s_valid !== 6'b000001) begin
      errors++; $display("FAIL pre_reset_access: got s_valid=%b expected 000001", s_valid);
    end
    #2 resetn = 1'b0; m_valid = 1'b0;
    #1;
    checks++;
    if ({s_valid, m_ready} !== 7'b0) begin
      errors++; $display("FAIL async_reset: got s_valid=%b m_ready=%b expected 000000/0", s_valid, m_ready);
    end
    @(posedge clk); #1 resetn = 1'b1;
    check_err("reset_clears_err", 1'b0, 2'b00, 32'h0, 8'd0);
    cfg_hang[0] = 1'b0;
    run_req(32'h1000_0004, 32'h0, 4'h0, 6'b000010, 1'b0, 2, 32'hC0DE_0101, 1, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; m_valid = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_wstrb = 4'h0;
    err_clear = 1'b0; cfg_hang = 6'b000000; extra_ready = 6'b000000;
    for (int i = 0; i < NS; i++) cfg_wait[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    test_reset();
    test_sram_read();
    test_slave5_write();
    test_priority();
    test_ignore_unselected();
    test_back_to_back();
    test_abort();
    cfg_hang[0] = 1'b0;
    test_unmapped();
    test_timeout();
    test_clear_collision();
    test_saturate();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
